fetch_unit: RTL and testbench

Instruction fetch stage that produces the `pc`/`instruction`/enable triple consumed by the IF→OF pipeline latch. It owns the fetch PC, issues requests to instruction memory over a valid/ready request and valid-only response handshake, and buffers returned words in a 2-entry queue. It drives `if_of_enable` only when a valid instruction (or a squash bubble) is presented.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks to instruction memory over a
// valid/ready request + valid-only response handshake, and buffers words in a 2-entry queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic        if_of_enable
);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] wait_pc_q, wait_pc_d;
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  logic pop, push, accept;
  logic room_idle, room_wait;

  always_comb begin
    pop             = !rst && (count_q != 2'd0) && !stall && !branch_taken;
    if_of_enable    = pop || (!rst && branch_taken);
    pc_out          = 32'h0;
    instruction_out = 32'h0;
    if (pop) begin
      pc_out          = fifo_pc_q[rd_ptr_q];
      instruction_out = fifo_instr_q[rd_ptr_q];
    end else if (if_of_enable) begin
      instruction_out = NOP_INSTR;
    end
  end

  // Room checks reserve a slot for the response of the request about to be issued.
  assign room_idle = ({1'b0, count_q} - 3'(pop)) < 3'd2;
  assign room_wait = ({1'b0, count_q} + 3'd1 - 3'(pop)) < 3'd2;

  always_comb begin
    imem_req_valid = 1'b0;
    case (state_q)
      StIdle:  imem_req_valid = room_idle;
      StWait:  imem_req_valid = imem_resp_valid && room_wait;
      default: imem_req_valid = 1'b0;
    endcase
    if (rst || branch_taken) imem_req_valid = 1'b0;
  end

  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req_valid && imem_req_ready;
  assign push      = !rst && (state_q == StWait) && imem_resp_valid && !branch_taken;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wait_pc_d  = wait_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (branch_taken) begin
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      fetch_pc_d = branch_target & ~32'h3;
      state_d    = (state_q != StIdle && !imem_resp_valid) ? StDrop : StIdle;
    end else begin
      count_d  = count_q + 2'(push) - 2'(pop);
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      case (state_q)
        StWait:  if (imem_resp_valid) state_d = StIdle;
        StDrop:  if (imem_resp_valid) state_d = StIdle;
        default: state_d = state_q;
      endcase
      if (accept) begin
        wait_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
        state_d    = StWait;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      wait_pc_q  <= 32'h0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wait_pc_q  <= wait_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= wait_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences and a
// randomized run scored against a queue-based model of the fetch stream.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, if_of_enable;
  logic [31:0] branch_target, imem_addr, imem_rdata, pc_out, instruction_out;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .if_of_enable    (if_of_enable)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned ep;
    int unsigned due;
  } mem_t;

  // ctl = {stall, branch_taken, imem_req_ready}; ex = {if_of_enable, imem_req_valid}
  typedef struct {
    logic [2:0]  ctl;
    logic [31:0] tgt;
    logic [1:0]  ex;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] addr;
  } vec_t;

  mem_t        memq[$];
  logic [31:0] avail[$];
  logic [31:0] acc_log[$];
  logic [31:0] exp_fetch, prev_addr;
  logic        prev_pend;
  int unsigned epoch, cyc, lat;
  logic        s_en, s_rv;
  logic [31:0] s_pc, s_ins, s_addr;
  int          passed = 0;
  int          total  = 0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    memq.delete();
    avail.delete();
    exp_fetch = RESET_PC;
    epoch     = 0;
    prev_pend = 1'b0;
    cyc       = 0;
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, score against the stream model.
  task automatic tick(input logic st, input logic br, input logic [31:0] tgt, input logic rdy);
    mem_t rec;
    logic resp, pop;
    stall           = st;
    branch_taken    = br;
    branch_target   = tgt;
    imem_req_ready  = rdy;
    resp            = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_resp_valid = resp;
    imem_rdata      = resp ? word_at(memq[0].addr) : 32'hDEAD_BEEF;
    @(negedge clk);
    s_en   = if_of_enable;
    s_rv   = imem_req_valid;
    s_pc   = pc_out;
    s_ins  = instruction_out;
    s_addr = imem_addr;
    rec    = '{32'h0, 0, 0};
    if (resp) rec = memq.pop_front();
    pop = !br && !st && (avail.size() > 0);
    check("enable", 32'(s_en), 32'(br || pop));
    if (pop) begin
      check("pc", s_pc, avail[0]);
      check("instr", s_ins, word_at(avail[0]));
    end else begin
      check("pc_idle", s_pc, 32'h0);
      check("instr_idle", s_ins, br ? NOP_INSTR : 32'h0);
    end
    if (br) check("req_in_redirect", 32'(s_rv), 32'h0);
    if (s_rv) check("req_addr", s_addr, exp_fetch);
    if (prev_pend && !br) begin
      check("req_hold", 32'(s_rv), 32'h1);
      check("addr_hold", s_addr, prev_addr);
    end
    prev_pend = s_rv && !rdy;
    prev_addr = s_addr;
    if (br) begin
      avail.delete();
      exp_fetch = tgt & ~32'h3;
      epoch++;
    end else begin
      if (pop) void'(avail.pop_front());
      if (resp && rec.ep == epoch) avail.push_back(rec.addr);
    end
    if (s_rv && rdy && !br) begin
      memq.push_back('{s_addr, epoch, cyc + lat});
      acc_log.push_back(s_addr);
      exp_fetch += 32'd4;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    stall           = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'h0;
    @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_enable", 32'(if_of_enable), 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_instr_out", instruction_out, 32'h0);
    rst = 1'b0;
    model_clear();
  endtask

  vec_t vecs[27];
  logic found;
  int   n_en;

  initial begin
    vecs[0]  = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h0};
    vecs[1]  = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h4};
    vecs[2]  = '{3'b001, 32'h0,   2'b11, 32'h0,   32'hA000_0000, 32'h8};
    vecs[3]  = '{3'b001, 32'h0,   2'b11, 32'h4,   32'hA000_0004, 32'hC};
    vecs[4]  = '{3'b001, 32'h0,   2'b11, 32'h8,   32'hA000_0008, 32'h10};
    vecs[5]  = '{3'b101, 32'h0,   2'b00, 32'h0,   32'h0,         32'h0};
    vecs[6]  = '{3'b101, 32'h0,   2'b00, 32'h0,   32'h0,         32'h0};
    vecs[7]  = '{3'b101, 32'h0,   2'b00, 32'h0,   32'h0,         32'h0};
    vecs[8]  = '{3'b001, 32'h0,   2'b11, 32'hC,   32'hA000_000C, 32'h14};
    vecs[9]  = '{3'b001, 32'h0,   2'b11, 32'h10,  32'hA000_0010, 32'h18};
    vecs[10] = '{3'b001, 32'h0,   2'b11, 32'h14,  32'hA000_0014, 32'h1C};
    vecs[11] = '{3'b001, 32'h0,   2'b11, 32'h18,  32'hA000_0018, 32'h20};
    vecs[12] = '{3'b000, 32'h0,   2'b11, 32'h1C,  32'hA000_001C, 32'h24};
    vecs[13] = '{3'b000, 32'h0,   2'b11, 32'h20,  32'hA000_0020, 32'h24};
    vecs[14] = '{3'b000, 32'h0,   2'b01, 32'h0,   32'h0,         32'h24};
    vecs[15] = '{3'b000, 32'h0,   2'b01, 32'h0,   32'h0,         32'h24};
    vecs[16] = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h24};
    vecs[17] = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h28};
    vecs[18] = '{3'b001, 32'h0,   2'b11, 32'h24,  32'hA000_0024, 32'h2C};
    vecs[19] = '{3'b011, 32'h103, 2'b10, 32'h0,   32'h0,         32'h0};
    vecs[20] = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h100};
    vecs[21] = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h104};
    vecs[22] = '{3'b001, 32'h0,   2'b11, 32'h100, 32'hA000_0100, 32'h108};
    vecs[23] = '{3'b111, 32'h200, 2'b10, 32'h0,   32'h0,         32'h0};
    vecs[24] = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h200};
    vecs[25] = '{3'b001, 32'h0,   2'b01, 32'h0,   32'h0,         32'h204};
    vecs[26] = '{3'b001, 32'h0,   2'b11, 32'h200, 32'hA000_0200, 32'h208};

    // Directed stream with a 1-cycle memory: stall, ready-low, redirects.
    lat = 1;
    do_reset();
    for (int i = 0; i < 27; i++) begin
      tick(vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].tgt, vecs[i].ctl[0]);
      check($sformatf("vec%0d_enable", i), 32'(s_en), 32'(vecs[i].ex[1]));
      check($sformatf("vec%0d_pc", i), s_pc, vecs[i].pc);
      check($sformatf("vec%0d_instr", i), s_ins, vecs[i].ins);
      check($sformatf("vec%0d_req_valid", i), 32'(s_rv), 32'(vecs[i].ex[0]));
      if (vecs[i].ex[0]) check($sformatf("vec%0d_addr", i), s_addr, vecs[i].addr);
    end

    // Redirect while the request to 0x10 is outstanding on a 3-cycle memory.
    lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_rv && s_addr == 32'h10) found = 1'b1;
    end
    check("drop_setup", 32'(found), 32'h1);
    tick(1'b0, 1'b1, 32'h100, 1'b1);
    check("drop_nop_enable", 32'(s_en), 32'h1);
    check("drop_nop_instr", s_ins, NOP_INSTR);
    check("drop_nop_pc", s_pc, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_rv) found = 1'b1;
    end
    check("drop_req_seen", 32'(found), 32'h1);
    check("drop_req_addr", s_addr, 32'h100);
    check("drop_resp_first", memq.size(), 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_en) found = 1'b1;
    end
    check("drop_present_seen", 32'(found), 32'h1);
    check("drop_present_pc", s_pc, 32'h100);

    // Reset while the queue is full under a stall.
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
    do_reset();
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("post_rst_req_valid", 32'(s_rv), 32'h1);
    check("post_rst_addr", s_addr, RESET_PC);
    check("post_rst_enable", 32'(s_en), 32'h0);

    // Fetch PC wrap at the top of the address space.
    acc_log.delete();
    tick(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    check("wrap_len", 32'(acc_log.size() >= 3), 32'h1);
    check("wrap_a0", acc_log[0], 32'hFFFF_FFF8);
    check("wrap_a1", acc_log[1], 32'hFFFF_FFFC);
    check("wrap_a2", acc_log[2], 32'h0000_0000);

    // Randomized traffic scored by the stream model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      lat = $urandom_range(1, 3);
      tick(($urandom % 5) == 0, ($urandom % 20) == 0, $urandom, ($urandom % 4) != 0);
    end
    lat = 1;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      if (s_en) n_en++;
    end
    check("steady_throughput", 32'(n_en >= 18), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
